// File: rtl/posit_seq_pkg.sv
// Shared types and constants for the posit dot-product sequencer.
`default_nettype none

package posit_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  localparam logic [7:0] POSIT_NAR  = 8'h80;
  localparam logic [7:0] POSIT_ZERO = 8'h00;
  localparam int         PAIR_W     = 16;

endpackage

`default_nettype wire

// File: rtl/posit_pair_fifo.sv
// Operand-pair FIFO: power-of-two depth, wrapping pointers, full-width occupancy count.
`default_nettype none

module posit_pair_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers rely on DEPTH being a power of two for modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/posit_dot_sequencer.sv
// Sequences buffered posit operand pairs through an external a*b+c MAC
// to accumulate a dot product of a requested length.
`default_nettype none

module posit_dot_sequencer
  import posit_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic [7:0]       mac_a,
  output logic [7:0]       mac_b,
  output logic [7:0]       mac_c,
  input  logic [7:0]       mac_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             busy,
  output logic             nar
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  seq_state_e        state_q, state_d;
  logic [7:0]        acc_q, acc_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              nar_q, nar_d;

  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [PAIR_W-1:0] fifo_head;

  posit_pair_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PAIR_W)
  ) u_pair_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .wdata ({in_a, in_b}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Raw memory head is undefined when empty; present zero operands instead.
  assign mac_a     = fifo_empty ? POSIT_ZERO : fifo_head[15:8];
  assign mac_b     = fifo_empty ? POSIT_ZERO : fifo_head[7:0];
  assign mac_c     = acc_q;
  assign in_ready  = !fifo_full;
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = acc_q;
  assign busy      = (state_q != ST_IDLE);
  assign nar       = nar_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    remaining_d = remaining_q;
    nar_d       = nar_q;
    fifo_pop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d       = POSIT_ZERO;
          nar_d       = 1'b0;
          remaining_d = len;
          state_d     = (len != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (fifo_count != '0) begin
          fifo_pop    = 1'b1;
          acc_d       = mac_res;
          remaining_d = remaining_q - LEN_W'(1);
          if (mac_res == POSIT_NAR) nar_d = 1'b1;
          if (remaining_q == LEN_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= POSIT_ZERO;
      remaining_q <= '0;
      nar_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      remaining_q <= remaining_d;
      nar_q       <= nar_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_posit_dot_sequencer.sv
// Scoreboard bench for posit_dot_sequencer with a behavioural posit<8,0> MAC.
`default_nettype none

module tb_posit_dot_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] len;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a, in_b;
  logic [7:0] mac_a, mac_b, mac_c, mac_res;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;
  logic       nar;

  typedef struct {
    logic [7:0] data;
    logic       nar;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  posit_dot_sequencer #(.DEPTH(4), .LEN_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_c     (mac_c),
    .mac_res   (mac_res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .nar       (nar)
  );

  // posit<8,0> decode to real; NaR is handled by the caller.
  function automatic real p2r(input logic [7:0] p);
    logic [7:0] m;
    logic       b;
    int         i, run, k, nf;
    real        frac, v;
    if (p == 8'h00) return 0.0;
    m = p[7] ? (~p + 8'd1) : p;
    b = m[6];
    run = 0;
    i = 6;
    while (i >= 0 && m[i] == b) begin
      run++;
      i--;
    end
    i--;
    k = b ? run - 1 : -run;
    frac = 0.0;
    nf = 0;
    for (int j = i; j >= 0; j--) begin
      frac = frac * 2.0 + (m[j] ? 1.0 : 0.0);
      nf++;
    end
    v = (2.0 ** k) * (1.0 + frac / (2.0 ** nf));
    return p[7] ? -v : v;
  endfunction

  // Nearest posit pattern, ties to the even pattern.
  function automatic logic [7:0] r2p(input real x);
    logic [7:0] best;
    real        best_err, err;
    if (x == 0.0) return 8'h00;
    best = 8'h01;
    best_err = 1.0e30;
    for (int p = 1; p < 256; p++) begin
      if (p != 128) begin
        err = p2r(8'(p)) - x;
        if (err < 0.0) err = -err;
        if (err < best_err || (err == best_err && p[0] == 1'b0)) begin
          best = 8'(p);
          best_err = err;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [7:0] posit_mac(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c);
    if (a == 8'h80 || b == 8'h80 || c == 8'h80) return 8'h80;
    return r2p(p2r(a) * p2r(b) + p2r(c));
  endfunction

  always_comb mac_res = posit_mac(mac_a, mac_b, mac_c);

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got %h want none", out_data);
      end else begin
        mon_e = sb_q.pop_front();
        chk("result_data", out_data, mon_e.data);
        chk("result_nar", {7'b0, nar}, {7'b0, mon_e.nar});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
    int n;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("push_ready", {7'b0, in_ready}, 8'd1);
    if (in_ready) tick();
    in_valid = 1'b0;
  endtask

  task automatic start_vec(input logic [7:0] l);
    start = 1'b1;
    len = l;
    tick();
    start = 1'b0;
  endtask

  task automatic expect_res(input logic [7:0] d, input logic n);
    exp_t e;
    e.data = d;
    e.nar = n;
    sb_q.push_back(e);
  endtask

  task automatic wait_out(input int budget);
    int n;
    n = 0;
    while (!out_valid && n < budget) begin
      tick();
      n++;
    end
    chk("out_valid_timeout", {7'b0, out_valid}, 8'd1);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    len = 8'd0;
    in_valid = 1'b0;
    in_a = 8'h00;
    in_b = 8'h00;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_busy", {7'b0, busy}, 8'd0);
    chk("rst_out_valid", {7'b0, out_valid}, 8'd0);
    chk("rst_in_ready", {7'b0, in_ready}, 8'd1);
    chk("rst_nar", {7'b0, nar}, 8'd0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_mac_a", mac_a, 8'h00);
    rst_n = 1'b1;
    tick();

    // 1.0*1.0 + 1.0*1.0 = 2.0
    push_pair(8'h40, 8'h40);
    push_pair(8'h40, 8'h40);
    expect_res(8'h60, 1'b0);
    start_vec(8'd2);
    wait_out(20);
    accept();
    chk("idle_after_accept", {7'b0, busy}, 8'd0);

    // Zero-length vector
    start_vec(8'd0);
    chk("len0_out_valid", {7'b0, out_valid}, 8'd1);
    chk("len0_out_data", out_data, 8'h00);
    chk("len0_busy", {7'b0, busy}, 8'd1);
    expect_res(8'h00, 1'b0);
    accept();
    chk("len0_idle", {7'b0, busy}, 8'd0);

    // NaR is sticky within a vector, cleared by the next start
    push_pair(8'h80, 8'h40);
    push_pair(8'h20, 8'h20);
    expect_res(8'h80, 1'b1);
    start_vec(8'd2);
    wait_out(20);
    accept();
    push_pair(8'h40, 8'h40);
    expect_res(8'h40, 1'b0);
    start_vec(8'd1);
    chk("nar_cleared", {7'b0, nar}, 8'd0);
    wait_out(20);
    accept();

    // FIFO fills at DEPTH; surplus pushes wait for drain. 1+2+0.5+1+4+0.5 -> 8.0
    push_pair(8'h40, 8'h40);
    push_pair(8'h40, 8'h60);
    push_pair(8'h20, 8'h40);
    push_pair(8'h40, 8'h40);
    chk("full_in_ready", {7'b0, in_ready}, 8'd0);
    in_valid = 1'b1;
    in_a = 8'h60;
    in_b = 8'h60;
    tick();
    tick();
    chk("full_hold_in_ready", {7'b0, in_ready}, 8'd0);
    in_valid = 1'b0;
    expect_res(8'h78, 1'b0);
    start_vec(8'd6);
    push_pair(8'h60, 8'h60);
    push_pair(8'h40, 8'h20);
    wait_out(40);
    accept();

    // Stall on empty FIFO, then hold the result under backpressure
    push_pair(8'h40, 8'h40);
    expect_res(8'h60, 1'b0);
    start_vec(8'd2);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("stall_acc", out_data, 8'h40);
      chk("stall_busy", {7'b0, busy}, 8'd1);
      chk("stall_out_valid", {7'b0, out_valid}, 8'd0);
      tick();
    end
    push_pair(8'h40, 8'h40);
    wait_out(20);
    for (int i = 0; i < 5; i++) begin
      chk("hold_out_valid", {7'b0, out_valid}, 8'd1);
      chk("hold_out_data", out_data, 8'h60);
      tick();
    end
    accept();

    // Asynchronous reset mid-vector discards everything
    push_pair(8'h40, 8'h40);
    push_pair(8'h40, 8'h40);
    push_pair(8'h40, 8'h40);
    start_vec(8'd3);
    tick();
    chk("pre_rst_acc", out_data, 8'h40);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {7'b0, busy}, 8'd0);
    chk("arst_out_valid", {7'b0, out_valid}, 8'd0);
    chk("arst_in_ready", {7'b0, in_ready}, 8'd1);
    chk("arst_out_data", out_data, 8'h00);
    chk("arst_nar", {7'b0, nar}, 8'd0);
    chk("arst_mac_a", mac_a, 8'h00);
    #1;
    rst_n = 1'b1;
    tick();
    push_pair(8'h40, 8'h40);
    expect_res(8'h40, 1'b0);
    start_vec(8'd1);
    wait_out(20);
    accept();

    repeat (3) tick();
    chk("scoreboard_drained", 8'(sb_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
